mul_arbiter: RTL

- Round-robin arbiter and sequencer that shares one instance of the team's 10-stage serial 8x8 shift-add multiplier among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and synchronises the multiplier's stage counter by pulsing its reset.
- Captures the 16-bit product at stage 9 and returns it with the requester ID over a valid/ready response channel.
- One operation is in flight at a time.

---
 rtl/mul_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one 10-stage serial 8x8 multiplier among NREQ requesters.
// Optional: define MUL_ARB_ZERO_BYPASS_EN to answer zero-operand requests without running the multiplier.
module mul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_in1,
  input  logic [8*NREQ-1:0]   req_in2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output logic [15:0]         resp_data,
  output logic                mul_rst,
  output logic [7:0]          mul_in1,
  output logic [7:0]          mul_in2,
  input  logic [15:0]         mul_out,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, RESP} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_op1;
  logic [7:0]      r_op2;
  logic [3:0]      r_cnt;
  logic            r_resp_valid;
  logic [ID_W-1:0] r_resp_id;
  logic [15:0]     r_resp_data;
  logic            r_busy;

  logic            w_grant_vld;
  logic [ID_W-1:0] w_grant;
  logic [7:0]      w_in1;
  logic [7:0]      w_in2;
  logic            w_accept;
  logic            w_zero;

  // Round-robin search: first valid index above r_last, otherwise wrap from 0 up to r_last.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_in1       = 8'd0;
    w_in2       = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && req_valid[i] && (ID_W'(i) > r_last)) begin
        w_grant_vld = 1'b1;
        w_grant     = ID_W'(i);
        w_in1       = req_in1[8*i +: 8];
        w_in2       = req_in2[8*i +: 8];
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && req_valid[i] && (ID_W'(i) <= r_last)) begin
        w_grant_vld = 1'b1;
        w_grant     = ID_W'(i);
        w_in1       = req_in1[8*i +: 8];
        w_in2       = req_in2[8*i +: 8];
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_grant_vld && !rst;

`ifdef MUL_ARB_ZERO_BYPASS_EN
  assign w_zero = (w_in1 == 8'd0) || (w_in2 == 8'd0);
`else
  assign w_zero = 1'b0;
`endif

  // One-hot accept strobe for the granted requester, only while idle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_accept && (w_grant == ID_W'(i));
    end
  end

  // Sequencer: accept, pulse the multiplier reset, count stages, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= ID_W'(NREQ - 1);
      r_id         <= '0;
      r_op1        <= 8'd0;
      r_op2        <= 8'd0;
      r_cnt        <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= 16'd0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op1  <= w_in1;
            r_op2  <= w_in2;
            r_id   <= w_grant;
            r_last <= w_grant;
            r_busy <= 1'b1;
            if (w_zero) begin
              r_resp_data  <= 16'd0;
              r_resp_id    <= w_grant;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_state <= SYNC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SYNC: begin
          r_cnt   <= 4'd0;
          r_state <= RUN;
        end
        RUN: begin
          // r_cnt tracks the multiplier stage; the product is valid at stage 9 only.
          if (r_cnt == 4'd9) begin
            r_resp_data  <= mul_out;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign mul_rst    = rst || (r_state == SYNC);
  assign mul_in1    = r_op1;
  assign mul_in2    = r_op2;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = r_busy;

endmodule
